// File: rtl/spi_slave_if.sv
// Bus-side signals of the SPI target: 68000-style strobed 16-bit register access plus interrupt.
interface spi_slave_if;
  logic [15:0] data_write;
  logic [15:0] data_read;
  logic [7:0]  addr;
  logic        uds;
  logic        lds;
  logic        rw;
  logic        ack;
  logic        irq;

  modport master (
    output data_write, addr, uds, lds, rw,
    input  data_read, ack, irq
  );

  modport slave (
    input  data_write, addr, uds, lds, rw,
    output data_read, ack, irq
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 target, MSB first, 8-bit frames, with single-byte RX/TX buffers behind a 16-bit register port.
// SPI pins are oversampled on clk; edges are detected after the synchroniser.
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  spi_slave_if.slave bus,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic sclk_r, cs_r, mosi_r;
  logic sclk_d, cs_d;

  logic [7:0] rx_shift;
  logic [7:0] rx_buf;
  logic [7:0] tx_buf;
  logic [7:0] shifter;
  logic [2:0] bit_cnt;
  logic       rx_full, rx_overrun, tx_full, tx_underrun, irq_en;

  logic cs_active, cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic byte_done, load;
  logic sel, rd, wr, rd_upper, wr_upper, wr_lower;
  logic [7:0] status;
  logic unused_bits;

  // Chip select idles deasserted through reset so no spurious select is seen on release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_r;
      cs_d      <= cs_r;
    end
  end

  assign sclk_r    = sclk_sync[SYNC_STAGES-1];
  assign cs_r      = cs_sync[SYNC_STAGES-1];
  assign mosi_r    = mosi_sync[SYNC_STAGES-1];

  assign cs_active = ~cs_r;
  assign cs_fall   = cs_d & ~cs_r;
  assign cs_rise   = ~cs_d & cs_r;
  assign sclk_rise = cs_active & sclk_r & ~sclk_d;
  assign sclk_fall = cs_active & ~sclk_r & sclk_d;

  assign byte_done = sclk_rise & (bit_cnt == 3'd7);
  assign load      = cs_fall | (sclk_fall & (bit_cnt == 3'd0));

  assign sel      = (bus.uds | bus.lds) & (bus.addr[7:1] == 7'd0);
  assign rd       = sel & bus.rw;
  assign wr       = sel & ~bus.rw;
  assign rd_upper = rd & bus.uds;
  assign wr_upper = wr & bus.uds;
  assign wr_lower = wr & bus.lds;

  assign status  = {irq_en, 2'b00, tx_underrun, rx_overrun, tx_full, rx_full, cs_active};
  assign bus.irq = rx_full & irq_en;

  assign unused_bits = ^{bus.addr[0], bus.data_write[6:5], bus.data_write[2:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ack       <= 1'b0;
      bus.data_read <= 16'h0000;
      irq_en        <= 1'b0;
    end else begin
      bus.ack <= sel;
      if (rd)
        bus.data_read <= {bus.uds ? rx_buf : 8'h00, bus.lds ? status : 8'h00};
      if (wr_lower)
        irq_en <= bus.data_write[7];
    end
  end

  // A byte completing in the same cycle as a uds read wins: the read returns the old byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_shift   <= 8'h00;
      bit_cnt    <= 3'd0;
      rx_buf     <= 8'h00;
      rx_full    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (cs_fall || cs_rise) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        rx_shift <= {rx_shift[6:0], mosi_r};
        bit_cnt  <= bit_cnt + 3'd1;
      end

      if (byte_done)
        rx_buf <= {rx_shift[6:0], mosi_r};

      if (byte_done)
        rx_full <= 1'b1;
      else if (rd_upper)
        rx_full <= 1'b0;

      if (byte_done && rx_full && !rd_upper)
        rx_overrun <= 1'b1;
      else if (wr_lower && bus.data_write[3])
        rx_overrun <= 1'b0;
    end
  end

  // A uds write coinciding with a load leaves the new byte pending for the next load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_buf      <= FILL_BYTE;
      tx_full     <= 1'b0;
      tx_underrun <= 1'b0;
      shifter     <= 8'h00;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      if (load) begin
        shifter <= tx_full ? tx_buf : FILL_BYTE;
        tx_full <= 1'b0;
      end else if (sclk_fall) begin
        shifter <= {shifter[6:0], 1'b0};
      end

      if (wr_upper) begin
        tx_buf  <= bus.data_write[15:8];
        tx_full <= 1'b1;
      end

      if (load && !tx_full)
        tx_underrun <= 1'b1;
      else if (wr_lower && bus.data_write[4])
        tx_underrun <= 1'b0;

      if (cs_fall)
        spi_miso_oe <= 1'b1;
      else if (cs_rise)
        spi_miso_oe <= 1'b0;

      if (cs_rise)
        spi_miso <= 1'b0;
      else if (spi_miso_oe)
        spi_miso <= shifter[7];
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Randomised scoreboard bench for spi_slave: a transaction-level model predicts every bus read and MISO byte.
module tb_spi_slave;
  localparam int          SYNC_STAGES = 2;
  localparam logic [7:0]  FILL_BYTE   = 8'hFF;
  localparam int          HALF        = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic spi_clk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe;

  spi_slave_if bus();

  spi_slave #(.SYNC_STAGES(SYNC_STAGES), .FILL_BYTE(FILL_BYTE)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .spi_clk(spi_clk),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_read;
    logic        uds;
    logic        lds;
    logic [15:0] exp;
  } bus_exp_t;

  bus_exp_t   bus_q[$];
  logic [7:0] miso_q[$];

  // Transaction-level model of the peripheral's visible state
  logic       m_tx_pend, m_rx_full, m_ovr, m_udr, m_irq_en, m_cs;
  logic [7:0] m_tx_byte, m_rx_buf;

  task automatic modelReset();
    m_tx_pend = 1'b0; m_tx_byte = FILL_BYTE; m_rx_buf = 8'h00; m_rx_full = 1'b0;
    m_ovr = 1'b0; m_udr = 1'b0; m_irq_en = 1'b0; m_cs = 1'b0;
  endtask

  function automatic logic [7:0] takeTx();
    if (m_tx_pend) begin
      m_tx_pend = 1'b0;
      return m_tx_byte;
    end
    m_udr = 1'b1;
    return FILL_BYTE;
  endfunction

  // One strobe cycle on the register port; expectations are queued for the monitor.
  task automatic applyStimulus(input logic [7:0] a, input logic u, input logic l,
                               input logic r, input logic [15:0] wd);
    bus_exp_t e;
    e = '0;
    if (a[7:1] == 7'd0 && (u || l)) begin
      e.is_read = r; e.uds = u; e.lds = l;
      if (r) begin
        if (l) e.exp[7:0] = {m_irq_en, 2'b00, m_udr, m_ovr, m_tx_pend, m_rx_full, m_cs};
        if (u) begin
          e.exp[15:8] = m_rx_buf;
          m_rx_full = 1'b0;
        end
      end else begin
        if (u) begin
          m_tx_byte = wd[15:8];
          m_tx_pend = 1'b1;
        end
        if (l) begin
          m_irq_en = wd[7];
          if (wd[3]) m_ovr = 1'b0;
          if (wd[4]) m_udr = 1'b0;
        end
      end
      bus_q.push_back(e);
    end
    bus.addr = a; bus.uds = u; bus.lds = l; bus.rw = r; bus.data_write = wd;
    @(negedge clk);
    bus.uds = 1'b0; bus.lds = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    if (bus.irq !== (m_rx_full & m_irq_en)) begin
      errors++;
      $display("[TB] FAIL %s irq: got %b expected %b", tag, bus.irq, m_rx_full & m_irq_en);
    end
    checks++;
    if (spi_miso_oe !== m_cs) begin
      errors++;
      $display("[TB] FAIL %s miso_oe: got %b expected %b", tag, spi_miso_oe, m_cs);
    end
  endtask

  // Mode-0 master: MOSI changes while SCLK is low, bits are sampled on the rising edge.
  task automatic spiFrame(input logic [15:0] data, input int nbits);
    logic [7:0] out;
    out = takeTx();
    for (int k = 0; k < nbits / 8; k++) begin
      miso_q.push_back(out);
      if (m_rx_full) m_ovr = 1'b1;
      m_rx_buf  = (k == 0) ? data[15:8] : data[7:0];
      m_rx_full = 1'b1;
      out = takeTx();
    end
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = data[15-i];
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  // Bus monitor: every ack must match a queued access
  bus_exp_t    mon_e;
  logic [15:0] mon_mask;
  int          ack_seen = 0;

  always @(negedge clk) begin
    if (bus.ack === 1'b1) begin
      ack_seen++;
      checks++;
      if (bus_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_ack: got ack=1 expected no access pending");
      end else begin
        mon_e = bus_q.pop_front();
        if (mon_e.is_read) begin
          mon_mask = {{8{mon_e.uds}}, {8{mon_e.lds}}};
          if ((bus.data_read & mon_mask) !== (mon_e.exp & mon_mask)) begin
            errors++;
            $display("[TB] FAIL bus_read uds=%b lds=%b: got %h expected %h",
                     mon_e.uds, mon_e.lds, bus.data_read & mon_mask, mon_e.exp & mon_mask);
          end
        end
      end
    end
  end

  // MISO monitor: assembles each byte the master samples
  int         miso_bits = 0;
  logic [7:0] miso_sh = 8'h00;
  logic [7:0] miso_exp;

  always @(posedge spi_clk or posedge spi_cs_n or negedge reset_n) begin
    if (!reset_n || spi_cs_n) begin
      miso_bits = 0;
    end else begin
      miso_sh = {miso_sh[6:0], spi_miso};
      miso_bits++;
      if (miso_bits == 8) begin
        miso_bits = 0;
        checks++;
        if (miso_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL miso_byte: got %h expected no byte", miso_sh);
        end else begin
          miso_exp = miso_q.pop_front();
          if (miso_sh !== miso_exp) begin
            errors++;
            $display("[TB] FAIL miso_byte: got %h expected %h", miso_sh, miso_exp);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int ack_before;

  initial begin
    bus.data_write = 16'h0; bus.addr = 8'h0; bus.uds = 1'b0; bus.lds = 1'b0; bus.rw = 1'b1;
    modelReset();
    repeat (3) @(negedge clk);

    checks++;
    if (bus.data_read !== 16'h0 || bus.ack !== 1'b0 || spi_miso !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got data_read=%h ack=%b miso=%b expected 0000 0 0",
               bus.data_read, bus.ack, spi_miso);
    end
    checkOutput("reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(8'h00, 1'b1, 1'b1, 1'b1, 16'h0);

    $display("[TB] basic frame");
    applyStimulus(8'h01, 1'b0, 1'b1, 1'b0, 16'h0080);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 16'hA500);
    spiFrame(16'h3C00, 8);
    checkOutput("frame_irq");
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1, 16'h0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1, 16'h0);

    $display("[TB] overrun");
    spiFrame(16'h1122, 16);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1, 16'h0);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 16'h0088);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1, 16'h0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1, 16'h0);
    checkOutput("overrun");

    $display("[TB] underrun");
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 16'h0010);
    spiFrame(16'h5A00, 8);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1, 16'h0);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 16'h0010);
    applyStimulus(8'h00, 1'b1, 1'b1, 1'b1, 16'h0);

    $display("[TB] partial frame");
    spiFrame(16'hF000, 5);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1, 16'h0);
    spiFrame(16'h8100, 8);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1, 16'h0);

    $display("[TB] status during frame and ack");
    spi_cs_n = 1'b0;
    m_cs = 1'b1;
    void'(takeTx());
    repeat (2 * HALF) @(negedge clk);
    checkOutput("selected");
    ack_before = ack_seen;
    applyStimulus(8'h01, 1'b0, 1'b1, 1'b1, 16'h0);
    @(negedge clk);
    checks++;
    if (ack_seen - ack_before != 1) begin
      errors++;
      $display("[TB] FAIL ack_count: got %0d expected 1", ack_seen - ack_before);
    end
    ack_before = ack_seen;
    applyStimulus(8'h04, 1'b1, 1'b1, 1'b1, 16'h0);
    repeat (2) @(negedge clk);
    checks++;
    if (ack_seen != ack_before) begin
      errors++;
      $display("[TB] FAIL ack_bad_addr: got %0d acks expected 0", ack_seen - ack_before);
    end
    spi_cs_n = 1'b1;
    m_cs = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    checkOutput("deselected");

    $display("[TB] reset mid-frame");
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 16'hC300);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 16'h0080);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      spi_mosi = i[0];
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    spi_cs_n = 1'b1;
    spi_clk = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1, 16'h0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 16'h6900);
    spiFrame(16'h9600, 8);
    applyStimulus(8'h00, 1'b1, 1'b1, 1'b1, 16'h0);

    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, 16'($urandom));
        1: spiFrame(16'($urandom), int'($urandom_range(1, 16)));
        2: applyStimulus(8'($urandom_range(0, 1)), 1'b1, 1'($urandom), 1'b1, 16'h0);
        3: applyStimulus(8'($urandom_range(0, 1)), 1'($urandom), 1'b1, 1'b1, 16'h0);
        default: applyStimulus(8'h01, 1'b0, 1'b1, 1'b0, 16'($urandom));
      endcase
      checkOutput("random");
    end

    for (int t = 0; t < 20 && (bus_q.size() != 0 || miso_q.size() != 0); t++)
      @(negedge clk);
    checks++;
    if (bus_q.size() != 0 || miso_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d bus and %0d miso pending expected 0 0",
               bus_q.size(), miso_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI target (mode 0, MSB first, 8-bit frames) with a 68000-style 16-bit register interface.
- Lets the FPGA act as a peripheral to an external SPI master, e.g. a debug host or a second board. It is the counterpart of the on-chip SPI master.
- External SPI pins are synchronised into the system clock and edge-detected; all logic runs on clk.
- Single-byte RX and TX buffers decouple the bus from the shift register.

Parameters:
SYNC_STAGES, 2, synchroniser flops on spi_clk, spi_cs_n and spi_mosi before edge detection (minimum 2)
FILL_BYTE, 8'hFF, byte shifted out when no TX byte is pending at a load point

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
data_write  in  16  bus write data
data_read  out  16  bus read data (registered)
addr  in  8  byte address within block
uds  in  1  upper data strobe (byte 0)
lds  in  1  lower data strobe (byte 1)
rw  in  1  1 = read, 0 = write
ack  out  1  registered access acknowledge
spi_clk  in  1  SCLK from external master
spi_cs_n  in  1  chip select from master, active low
spi_mosi  in  1  data from master
spi_miso  out  1  data to master
spi_miso_oe  out  1  MISO output enable, 1 while selected
irq  out  1  rx_full & irq_en

Behaviour:
- Reset: all registers are cleared, asynchronously, with these values.
  - ack=0, data_read=0, spi_miso=0, spi_miso_oe=0, irq=0.
  - rx_buf=0, tx_buf=FILL_BYTE, shifter=0, bit_cnt=0.
  - All status flags are 0, and irq_en=0.
- Register map (decoded when addr[7:1]==0; other addresses get no ack):
  - uds read: data_read[15:8]=rx_buf. Clears rx_full.
  - lds read: data_read[7:0] = {irq_en, 2'b0, tx_underrun, rx_overrun, tx_full, rx_full, cs_active}.
  - uds write: tx_buf=data_write[15:8], tx_full=1. A write while tx_full is set overwrites the pending byte.
  - lds write:
    - irq_en=data_write[7].
    - data_write[3]=1 clears rx_overrun.
    - data_write[4]=1 clears tx_underrun.
- Bus handshake:
  - ack=1 in the cycle after any cycle with (uds|lds) asserted and the address matched; otherwise 0.
  - No wait states are inserted.
  - Side effects (rx_full clear, tx_full set, flag clears) happen once per cycle in which the strobe is present.
- Synchroniser and edges:
  - sclk_r, cs_r and mosi_r are the SYNC_STAGES-delayed copies; one extra flop on sclk_r and cs_r gives edge detects.
  - cs_active=~cs_r.
  - Required spi_clk high and low times: at least SYNC_STAGES+1 clk periods each.
- CS falling edge (select):
  - bit_cnt=0, spi_miso_oe=1.
  - shifter = tx_buf if tx_full, else FILL_BYTE and tx_underrun=1.
  - tx_full=0.
  - spi_miso=shifter[7] next cycle.
- SCLK rising edge while cs_active:
  - rx_shift = {rx_shift[6:0], mosi_r}; bit_cnt++.
  - When bit_cnt reaches 8 it wraps to 0, rx_buf=completed byte, rx_full=1.
  - If rx_full was already 1 and no uds read occurs that cycle, rx_overrun=1 and rx_buf is overwritten.
- SCLK falling edge while cs_active:
  - If bit_cnt==0 (byte boundary), reload the shifter with the CS-select rule (tx_buf or FILL_BYTE plus underrun).
  - Otherwise shift left. spi_miso follows shifter[7].
- CS rising edge (deselect):
  - spi_miso_oe=0, spi_miso=0.
  - A partial byte (bit_cnt≠0) is discarded: rx_full unchanged, bit_cnt=0.
  - tx_buf is unaffected.
- Edges of spi_clk seen while CS is high are ignored.
- Simultaneous events:
  - If a byte completes in the same cycle as a uds read, data_read returns the old rx_buf, rx_full stays 1 and there is no overrun.
  - If a uds write happens in the same cycle as a shifter load, the shifter takes the previous tx_buf (or FILL_BYTE), and the new byte stays pending with tx_full=1.
- Asynchronous reset asserted mid-frame aborts the frame; MISO is released immediately.

Test Plan:
- Write uds 0xA5, then the master selects and clocks 8 bits with MOSI=0x3C. Required: MISO bits 1,0,1,0,0,1,0,1, then rx_buf=0x3C, rx_full=1, tx_full=0, irq=1 if irq_en.
- Master clocks 2 bytes (0x11, 0x22) with no read in between. Required: rx_overrun=1, rx_buf=0x22. Writing lds 0x08 clears rx_overrun; a uds read returns 0x22 and clears rx_full.
- Frame with no TX byte written. Required: MISO=0xFF, tx_underrun=1. Writing lds 0x10 clears it.
- CS deasserted after 5 bits of 0xF0. Required: rx_full stays 0. The next full frame of 0x81 yields rx_buf=0x81.
- Read lds during an active frame. Required: bit0=1. ack pulses exactly one cycle after each strobe cycle. addr=0x04 gives no ack.
- reset_n asserted mid-frame. Required: spi_miso_oe=0 and all flags 0 immediately. The following frame behaves normally.
